bmp_upload_streamer: RTL and testbench
======================================

// Module: bmp_upload_streamer
// PURPOSE
//   Upload-side counterpart of the menu core's BMP download path. While the host
//   reads a file back (ioctl_upload), it presents one byte per ioctl_addr on ioctl_din.
//   Bytes 0..53 are a generated BMP header. Later bytes are 32bpp pixel data, fetched
//   word-wise from the SDRAM read port that the download path fills linearly.
//   Sits between data_io (upload side) and one SDRAM port, on clk_sys.
// PARAMETERS
//   IMG_W     640   image width in pixels; also the word stride per line in memory
//   IMG_H     312   image height in lines (positive in header => bottom-up order)
//   MEM_AW    22    SDRAM word-address width (32-bit words)
//   MEM_BASE  0     word address of pixel 0 (first file pixel)
// PORTS
//   clk_sys          in   1       single clock
//   reset            in   1       synchronous, active-high
//   ioctl_upload     in   1       high for the whole upload
//   ioctl_addr       in   25      file byte offset requested by data_io
//   ioctl_din        out  8       byte for ioctl_addr
//   ioctl_din_valid  out  1       ioctl_din matches the current ioctl_addr
//   mem_req          out  1       toggle-request to SDRAM read port
//   mem_ack          in   1       equals mem_req when the read has completed
//   mem_addr         out  MEM_AW  word address, stable while mem_req != mem_ack
//   mem_q            in   32      read data, valid when mem_ack == mem_req
//   busy             out  1       upload session active or a fetch outstanding
// BEHAVIOUR
//   Reset: ioctl_din=0, ioctl_din_valid=0, mem_req=0, mem_addr=0, busy=0,
//     buf_valid=0, state=IDLE.
//   Constants (32-bit, little-endian in file):
//     FSIZE = 54 + IMG_W*IMG_H*4, ISIZE = IMG_W*IMG_H*4.
//   Header bytes:
//     0-1 "BM"; 2-5 FSIZE; 6-9 0; 10-13 54; 14-17 40; 18-21 IMG_W; 22-25 IMG_H;
//     26-27 1; 28-29 32; 30-33 0; 34-37 ISIZE; 38-45 2835,2835; 46-53 0.
//   Pixel region, a = ioctl_addr-54 for 54 <= ioctl_addr < FSIZE:
//     pix = a>>2, lane = a[1:0].
//     lane 0=mem_q[7:0] B, 1=[15:8] G, 2=[23:16] R, 3=[31:24] X.
//   ioctl_addr >= FSIZE: ioctl_din = 0x00, no fetch.
//   FSM: IDLE -> SERVE on ioctl_upload rising edge; busy=1 from the next cycle.
//     SERVE, addr changed (vs registered copy) or first cycle: ioctl_din_valid=0.
//       header/out-of-range: ioctl_din registered, valid after 1 cycle.
//       pixel, buf_valid and buf_pix==pix: lane byte, valid after 1 cycle.
//       pixel, buffer miss: mem_addr<=MEM_BASE+pix, toggle mem_req -> FETCH.
//     FETCH: wait until mem_ack==mem_req. Then buf<=mem_q, buf_pix<=pix,
//       buf_valid<=1, -> SERVE.
//       SERVE then re-evaluates against the latest ioctl_addr. An address change
//       during FETCH never outputs a stale byte.
//     Exactly one request outstanding at a time. mem_req toggles once per fetch.
//   ioctl_upload falls in SERVE -> IDLE at once. Falls in FETCH -> DRAIN (wait ack,
//     discard data) -> IDLE.
//     In both cases buf_valid=0, ioctl_din_valid=0. busy drops on entering IDLE.
//   Upload rising edge while in DRAIN: the session starts after the drain completes.
//   reset mid-fetch: forces IDLE and mem_req=0. The SDRAM port is reset together,
//     so the request is abandoned.
//   Address arithmetic is 25-bit unsigned. The a>>2 result is truncated to MEM_AW.
//   pix wrap past the image is impossible because of the FSIZE guard.
// STRUCTURE
//   Shared include bmp_defs.vh: header offsets, BMP_HDR_BYTES=54, DIB_SIZE=40, BPP=32,
//   PPM=2835, and the FSIZE/ISIZE functions of IMG_W/IMG_H. The download parser uses
//   the same include for offsets 10-12.
//   Sub-module bmp_hdr_rom: combinational, byte index[5:0] + IMG_W/IMG_H -> header byte.
//   Top: FSM, address compare register, 1-word buffer, toggle handshake.
// TESTING
//   1 Upload addr 0..5 -> 42 4D 36 30 0C 00 (FSIZE=798774=0x000C3036); no mem_req toggle.
//   2 Addr 18..25 -> 80 02 00 00 38 01 00 00; addr 28 -> 0x20; addr 10 -> 0x36.
//   3 Addr 54, mem_q=0x00112233 -> one toggle, mem_addr=MEM_BASE; din 33.
//     Then addr 55,56,57 -> 22,11,00 with no toggle; addr 58 -> toggle, mem_addr=MEM_BASE+1.
//   4 Addr 54 held, ack delayed 20 cycles; ioctl_addr jumps to 62 during FETCH
//     -> valid stays 0. After ack, a second fetch of MEM_BASE+2; din = lane 0 of the new word.
//   5 Addr 798774 -> 0x00, valid after 1 cycle, no toggle.
//   6 Drop ioctl_upload mid-FETCH -> DRAIN until ack, then busy=0 and valid=0.
//     Assert reset mid-FETCH -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/bmp_upload_streamer_pkg.sv
// Shared BMP definitions for the upload streamer (and the download parser):
// header layout constants, size helpers and the streamer FSM state type.
package bmp_upload_streamer_pkg;

   localparam int BMP_HDR_BYTES = 54;
   localparam int DIB_SIZE      = 40;
   localparam int BPP           = 32;
   localparam int PPM           = 2835;

   // Byte offsets of the multi-byte header fields
   localparam int OFS_FSIZE  = 2;
   localparam int OFS_DATA   = 10;
   localparam int OFS_DIB    = 14;
   localparam int OFS_WIDTH  = 18;
   localparam int OFS_HEIGHT = 22;
   localparam int OFS_PLANES = 26;
   localparam int OFS_ISIZE  = 34;
   localparam int OFS_XPPM   = 38;
   localparam int OFS_YPPM   = 42;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_FETCH,
      ST_DRAIN
   } state_e;

   function automatic logic [31:0] bmp_isize(input int w, input int h);
      return 32'(w * h * 4);
   endfunction

   function automatic logic [31:0] bmp_fsize(input int w, input int h);
      return 32'(BMP_HDR_BYTES) + bmp_isize(w, h);
   endfunction

   // Little-endian byte k of a 32-bit field
   function automatic logic [7:0] le_byte(input logic [31:0] f, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = f[7:0];
         2'd1:    b = f[15:8];
         2'd2:    b = f[23:16];
         default: b = f[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bmp_upload_streamer_hdr_rom.sv
// Combinational BMP header generator: byte index 0..53 -> header byte.
module bmp_upload_streamer_hdr_rom
   import bmp_upload_streamer_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 312
) (
   input  logic [5:0] idx_i,
   output logic [7:0] byte_o
);

   localparam logic [31:0] FSIZE = bmp_fsize(IMG_W, IMG_H);
   localparam logic [31:0] ISIZE = bmp_isize(IMG_W, IMG_H);

   logic [31:0] fld;
   logic [5:0]  base;

   // Select the 32-bit field covering idx_i and its starting offset
   always_comb begin
      fld  = '0;
      base = idx_i;
      if (idx_i < 6'd2) begin
         fld  = '0;
         base = idx_i;
      end else if (idx_i < 6'd6) begin
         fld  = FSIZE;
         base = 6'(OFS_FSIZE);
      end else if (idx_i < 6'd10) begin
         fld  = '0;
         base = 6'd6;
      end else if (idx_i < 6'd14) begin
         fld  = 32'(BMP_HDR_BYTES);
         base = 6'(OFS_DATA);
      end else if (idx_i < 6'd18) begin
         fld  = 32'(DIB_SIZE);
         base = 6'(OFS_DIB);
      end else if (idx_i < 6'd22) begin
         fld  = 32'(IMG_W);
         base = 6'(OFS_WIDTH);
      end else if (idx_i < 6'd26) begin
         fld  = 32'(IMG_H);
         base = 6'(OFS_HEIGHT);
      end else if (idx_i < 6'd30) begin
         // planes (16-bit) followed by bits-per-pixel (16-bit)
         fld  = {16'(BPP), 16'd1};
         base = 6'(OFS_PLANES);
      end else if (idx_i < 6'd34) begin
         fld  = '0;
         base = 6'd30;
      end else if (idx_i < 6'd38) begin
         fld  = ISIZE;
         base = 6'(OFS_ISIZE);
      end else if (idx_i < 6'd42) begin
         fld  = 32'(PPM);
         base = 6'(OFS_XPPM);
      end else if (idx_i < 6'd46) begin
         fld  = 32'(PPM);
         base = 6'(OFS_YPPM);
      end
   end

   // Signature bytes are special, everything else is a little-endian field byte
   always_comb begin
      if (idx_i == 6'd0)      byte_o = 8'h42;
      else if (idx_i == 6'd1) byte_o = 8'h4D;
      else                    byte_o = le_byte(fld, 2'(idx_i - base));
   end

endmodule

// File: rtl/bmp_upload_streamer.sv
// Upload-side BMP streamer: serves header bytes from a generated ROM and pixel
// bytes from a one-word buffer refilled over a toggle-handshake SDRAM read port.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_IDLE  | no upload session, waiting for ioctl_upload rising edge
// ST_SERVE | session active, answering ioctl_addr from ROM or pixel buffer
// ST_FETCH | one SDRAM word read outstanding for the requested pixel
// ST_DRAIN | upload ended mid-fetch, waiting for the ack and discarding data
module bmp_upload_streamer
   import bmp_upload_streamer_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 312,
   parameter int MEM_AW   = 22,
   parameter int MEM_BASE = 0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_din_valid,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_q,
   output logic              busy
);

   localparam logic [24:0] HDR_A   = 25'(BMP_HDR_BYTES);
   localparam logic [24:0] FSIZE_A = 25'(bmp_fsize(IMG_W, IMG_H));

   state_e            state_q, state_d;
   logic [24:0]       addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              din_valid_q, din_valid_d;
   logic              req_q, req_d;
   logic [MEM_AW-1:0] maddr_q, maddr_d;
   logic [31:0]       buf_q, buf_d;
   logic [MEM_AW-1:0] buf_pix_q, buf_pix_d;
   logic              buf_valid_q, buf_valid_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              upload_q;

   logic [24:0]       a_off;
   logic [MEM_AW-1:0] pix;
   logic [1:0]        lane;
   logic              is_hdr;
   logic              is_oob;
   logic              ack_match;
   logic              upload_rise;
   logic [7:0]        hdr_byte;
   logic [7:0]        lane_byte;

   bmp_upload_streamer_hdr_rom #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_hdr_rom (
      .idx_i  (ioctl_addr[5:0]),
      .byte_o (hdr_byte)
   );

   // Decode the requested address into region, pixel index and byte lane
   always_comb begin
      a_off       = ioctl_addr - HDR_A;
      pix         = MEM_AW'(a_off >> 2);
      lane        = a_off[1:0];
      is_hdr      = (ioctl_addr < HDR_A);
      is_oob      = (ioctl_addr >= FSIZE_A);
      ack_match   = (mem_ack == req_q);
      upload_rise = ioctl_upload & ~upload_q;
      lane_byte   = le_byte(buf_q, lane);
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      din_d       = din_q;
      din_valid_d = din_valid_q;
      req_d       = req_q;
      maddr_d     = maddr_q;
      buf_d       = buf_q;
      buf_pix_d   = buf_pix_q;
      buf_valid_d = buf_valid_q;
      pend_d      = pend_q;

      case (state_q)
         ST_IDLE: begin
            din_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            pend_d      = 1'b0;
            if (upload_rise) state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (!ioctl_upload) begin
               state_d     = ST_IDLE;
               din_valid_d = 1'b0;
               buf_valid_d = 1'b0;
            end else if (!din_valid_q || ioctl_addr != addr_q) begin
               addr_d = ioctl_addr;
               if (is_hdr) begin
                  din_d       = hdr_byte;
                  din_valid_d = 1'b1;
               end else if (is_oob) begin
                  din_d       = 8'h00;
                  din_valid_d = 1'b1;
               end else if (buf_valid_q && buf_pix_q == pix) begin
                  din_d       = lane_byte;
                  din_valid_d = 1'b1;
               end else begin
                  din_valid_d = 1'b0;
                  maddr_d     = MEM_AW'(MEM_BASE) + pix;
                  req_d       = ~req_q;
                  buf_valid_d = 1'b0;
                  buf_pix_d   = pix;
                  state_d     = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            din_valid_d = 1'b0;
            if (!ioctl_upload) begin
               buf_valid_d = 1'b0;
               pend_d      = 1'b0;
               state_d     = ack_match ? ST_IDLE : ST_DRAIN;
            end else if (ack_match) begin
               // SERVE re-evaluates against whatever address is current now
               buf_d       = mem_q;
               buf_valid_d = 1'b1;
               state_d     = ST_SERVE;
            end
         end
         ST_DRAIN: begin
            din_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            if (upload_rise) pend_d = 1'b1;
            if (ack_match) begin
               state_d = (pend_q || upload_rise) ? ST_SERVE : ST_IDLE;
               pend_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         din_valid_q <= 1'b0;
         req_q       <= 1'b0;
         maddr_q     <= '0;
         buf_q       <= '0;
         buf_pix_q   <= '0;
         buf_valid_q <= 1'b0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         upload_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         din_valid_q <= din_valid_d;
         req_q       <= req_d;
         maddr_q     <= maddr_d;
         buf_q       <= buf_d;
         buf_pix_q   <= buf_pix_d;
         buf_valid_q <= buf_valid_d;
         pend_q      <= pend_d;
         busy_q      <= busy_d;
         upload_q    <= ioctl_upload;
      end
   end

   // Valid only while the registered byte still belongs to the live address
   always_comb begin
      ioctl_din       = din_q;
      ioctl_din_valid = din_valid_q && (ioctl_addr == addr_q);
      mem_req         = req_q;
      mem_addr        = maddr_q;
      busy            = busy_q;
   end

endmodule

// File: tb/tb_bmp_upload_streamer.sv
// Directed bench for bmp_upload_streamer with a delayed-ack SDRAM model.
module tb_bmp_upload_streamer;

   localparam int MEM_AW = 22;

   logic              clk_sys = 1'b0;
   logic              reset = 1'b1;
   logic              ioctl_upload = 1'b0;
   logic [24:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_din;
   logic              ioctl_din_valid;
   logic              mem_req;
   logic              mem_ack;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_q;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;
   int toggles = 0;
   int ack_delay = 2;
   int ack_cnt = 0;

   bmp_upload_streamer #(
      .IMG_W    (640),
      .IMG_H    (312),
      .MEM_AW   (MEM_AW),
      .MEM_BASE (0)
   ) dut (
      .clk_sys         (clk_sys),
      .reset           (reset),
      .ioctl_upload    (ioctl_upload),
      .ioctl_addr      (ioctl_addr),
      .ioctl_din       (ioctl_din),
      .ioctl_din_valid (ioctl_din_valid),
      .mem_req         (mem_req),
      .mem_ack         (mem_ack),
      .mem_addr        (mem_addr),
      .mem_q           (mem_q),
      .busy            (busy)
   );

   always #5 clk_sys = ~clk_sys;

   // Word k of memory = 0x00112233 + k*0x01010101
   function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] k);
      return 32'h0011_2233 + 32'(k) * 32'h0101_0101;
   endfunction

   // SDRAM read port model: completes a toggle request after ack_delay cycles
   always @(posedge clk_sys) begin
      if (reset) begin
         mem_ack <= 1'b0;
         mem_q   <= '0;
         ack_cnt <= 0;
      end else if (mem_req != mem_ack) begin
         if (ack_cnt >= ack_delay) begin
            mem_ack <= mem_req;
            mem_q   <= mem_word(mem_addr);
            ack_cnt <= 0;
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end
   end

   always @(mem_req) if (!reset) toggles = toggles + 1;

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_sys);
         if (ioctl_din_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      n_cmp++; if (ioctl_din !== 8'h00) begin n_err++; $display("FAIL reset_din got %h exp 00", ioctl_din); end
      n_cmp++; if (ioctl_din_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ioctl_din_valid); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", mem_req); end
      n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_maddr got %h exp 0", mem_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic start_upload();
      ioctl_addr   = 25'd0;
      ioctl_upload = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", busy); end
   endtask

   task automatic test_header();
      int          addrs [16] = '{0, 1, 2, 3, 4, 5, 18, 19, 20, 21, 22, 23, 24, 25, 28, 10};
      logic [7:0]  exps  [16] = '{8'h42, 8'h4D, 8'h36, 8'h30, 8'h0C, 8'h00,
                                  8'h80, 8'h02, 8'h00, 8'h00, 8'h38, 8'h01, 8'h00, 8'h00,
                                  8'h20, 8'h36};
      int t0;
      bit ok;
      t0 = toggles;
      for (int i = 0; i < 16; i++) begin
         ioctl_addr = 25'(addrs[i]);
         wait_valid(4, ok);
         n_cmp++; if (!ok || ioctl_din !== exps[i]) begin n_err++; $display("FAIL hdr_byte addr %0d got %h valid %b exp %h", addrs[i], ioctl_din, ok, exps[i]); end
      end
      n_cmp++; if (toggles !== t0) begin n_err++; $display("FAIL hdr_no_toggle got %0d exp %0d", toggles - t0, 0); end
   endtask

   task automatic test_pixel();
      int         t0;
      bit         ok;
      logic [7:0] exps [3] = '{8'h22, 8'h11, 8'h00};
      ack_delay = 2;
      t0 = toggles;
      ioctl_addr = 25'd54;
      wait_valid(30, ok);
      n_cmp++; if (toggles !== t0 + 1) begin n_err++; $display("FAIL pix0_toggles got %0d exp 1", toggles - t0); end
      n_cmp++; if (mem_addr !== 22'd0) begin n_err++; $display("FAIL pix0_maddr got %h exp 0", mem_addr); end
      n_cmp++; if (!ok || ioctl_din !== 8'h33) begin n_err++; $display("FAIL pix0_lane0 got %h valid %b exp 33", ioctl_din, ok); end
      for (int i = 0; i < 3; i++) begin
         ioctl_addr = 25'(55 + i);
         wait_valid(4, ok);
         n_cmp++; if (!ok || ioctl_din !== exps[i]) begin n_err++; $display("FAIL pix0_lane%0d got %h valid %b exp %h", i + 1, ioctl_din, ok, exps[i]); end
      end
      n_cmp++; if (toggles !== t0 + 1) begin n_err++; $display("FAIL pix0_hit_no_toggle got %0d exp 1", toggles - t0); end
      ioctl_addr = 25'd58;
      wait_valid(30, ok);
      n_cmp++; if (toggles !== t0 + 2) begin n_err++; $display("FAIL pix1_toggles got %0d exp 2", toggles - t0); end
      n_cmp++; if (mem_addr !== 22'd1) begin n_err++; $display("FAIL pix1_maddr got %h exp 1", mem_addr); end
      n_cmp++; if (!ok || ioctl_din !== 8'h34) begin n_err++; $display("FAIL pix1_lane0 got %h valid %b exp 34", ioctl_din, ok); end
   endtask

   task automatic test_fetch_redirect();
      int t0;
      int bad;
      bit ok;
      ack_delay = 20;
      t0 = toggles;
      bad = 0;
      ioctl_addr = 25'd54;
      repeat (3) @(negedge clk_sys);
      ioctl_addr = 25'd62;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         if (ioctl_din_valid !== 1'b0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL redirect_valid_low got %0d valid cycles exp 0", bad); end
      wait_valid(80, ok);
      n_cmp++; if (toggles !== t0 + 2) begin n_err++; $display("FAIL redirect_toggles got %0d exp 2", toggles - t0); end
      n_cmp++; if (mem_addr !== 22'd2) begin n_err++; $display("FAIL redirect_maddr got %h exp 2", mem_addr); end
      n_cmp++; if (!ok || ioctl_din !== 8'h35) begin n_err++; $display("FAIL redirect_din got %h valid %b exp 35", ioctl_din, ok); end
   endtask

   task automatic test_oob();
      int t0;
      t0 = toggles;
      ioctl_addr = 25'd798774;
      @(negedge clk_sys);
      n_cmp++; if (ioctl_din_valid !== 1'b1 || ioctl_din !== 8'h00) begin n_err++; $display("FAIL oob_byte got %h valid %b exp 00 valid 1", ioctl_din, ioctl_din_valid); end
      ioctl_addr = 25'd53;
      @(negedge clk_sys);
      n_cmp++; if (ioctl_din_valid !== 1'b1 || ioctl_din !== 8'h00) begin n_err++; $display("FAIL hdr_last got %h valid %b exp 00 valid 1", ioctl_din, ioctl_din_valid); end
      n_cmp++; if (toggles !== t0) begin n_err++; $display("FAIL oob_no_toggle got %0d exp 0", toggles - t0); end
   endtask

   task automatic test_drain();
      int t0;
      bit done;
      ack_delay = 10;
      t0 = toggles;
      ioctl_addr = 25'd70;
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      n_cmp++; if (busy !== 1'b1 || ioctl_din_valid !== 1'b0) begin n_err++; $display("FAIL drain_busy got busy %b valid %b exp 1 0", busy, ioctl_din_valid); end
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      n_cmp++; if (!done || mem_ack !== mem_req) begin n_err++; $display("FAIL drain_done got idle %b ack %b req %b exp idle 1 ack==req", done, mem_ack, mem_req); end
      n_cmp++; if (ioctl_din_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b exp 0", ioctl_din_valid); end
      n_cmp++; if (toggles !== t0 + 1) begin n_err++; $display("FAIL drain_toggles got %0d exp 1", toggles - t0); end
   endtask

   task automatic test_reset_mid_fetch();
      ack_delay = 20;
      start_upload();
      ioctl_addr = 25'd74;
      repeat (4) @(negedge clk_sys);
      n_cmp++; if (mem_req === mem_ack) begin n_err++; $display("FAIL rstfetch_pending got req %b ack %b exp differ", mem_req, mem_ack); end
      reset = 1'b1;
      @(negedge clk_sys);
      n_cmp++; if (ioctl_din !== 8'h00 || ioctl_din_valid !== 1'b0) begin n_err++; $display("FAIL rstfetch_din got %h valid %b exp 00 0", ioctl_din, ioctl_din_valid); end
      n_cmp++; if (mem_req !== 1'b0 || mem_addr !== '0) begin n_err++; $display("FAIL rstfetch_mem got req %b addr %h exp 0 0", mem_req, mem_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstfetch_busy got %b exp 0", busy); end
      ioctl_upload = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
   endtask

   initial begin
      test_reset();
      start_upload();
      test_header();
      test_pixel();
      test_fetch_redirect();
      test_oob();
      test_drain();
      test_reset_mid_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
